// File: rtl/multichan_edge_detect_veto.sv
// -----------------------------------------------------------------------------
// multichan_edge_detect_veto
//
// Multi-channel photon edge detector with a programmable dead-time veto and
// per-channel hit/veto counters. Each asynchronous discriminator input is
// synchronised and rising-edge detected. An edge is suppressed when an earlier
// edge falls inside the window selected by veto_mask. That earlier edge may be
// on the same channel, or on any channel when veto_global is set. Accepted
// edges appear on det as a registered one-cycle pulse.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high; clears sync, history, det, counters
//   pulse_in     [NCHAN]        asynchronous photon pulses, any length
//   enable       1 = detect edges, 0 = ignore edges (sync chains keep running)
//   veto_mask    [VETO_DEPTH]   bit k: veto edges k+1 cycles after a prior edge
//   veto_global  0 = per-channel history, 1 = OR of all channels' history
//   clear_cnt    synchronous clear of all counters (wins over increments)
//   det          [NCHAN]        one-cycle detection pulse per channel
//   hit_cnt      [NCHAN*CNT_W]  saturating accepted-edge counts, ch c at
//                               [c*CNT_W +: CNT_W]
//   veto_cnt     [NCHAN*CNT_W]  saturating vetoed-edge counts, same packing
// -----------------------------------------------------------------------------
module multichan_edge_detect_veto #(
    parameter int NCHAN       = 4,
    parameter int VETO_DEPTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCHAN-1:0]         pulse_in,
    input  logic                     enable,
    input  logic [VETO_DEPTH-1:0]    veto_mask,
    input  logic                     veto_global,
    input  logic                     clear_cnt,
    output logic [NCHAN-1:0]         det,
    output logic [NCHAN*CNT_W-1:0]   hit_cnt,
    output logic [NCHAN*CNT_W-1:0]   veto_cnt
);

    // Synchroniser chain per channel; bit 0 is the first flop and
    // bit SYNC_STAGES-1 is the last, metastability-safe stage.
    logic [SYNC_STAGES-1:0] sync_q [NCHAN];
    logic [NCHAN-1:0]       sync_d;

    // Edge history per channel: hist[c][k] = raw edge k+1 cycles ago.
    logic [VETO_DEPTH-1:0]  hist [NCHAN];
    logic [VETO_DEPTH-1:0]  hist_any;

    logic [NCHAN-1:0]       raw;
    logic [NCHAN-1:0]       veto;
    logic [NCHAN-1:0]       accept;
    logic [NCHAN-1:0]       reject;

    logic [CNT_W-1:0]       hit_q  [NCHAN];
    logic [CNT_W-1:0]       veto_q [NCHAN];

    // -------------------------------------------------------------------------
    // Input synchronisation and one-cycle delay of the synchronised level
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                sync_q[c] <= '0;
            end
            sync_d <= '0;
        end else begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], pulse_in[c]};
                sync_d[c] <= sync_q[c][SYNC_STAGES-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Edge detection and veto decision
    // -------------------------------------------------------------------------
    always_comb begin
        hist_any = '0;
        raw      = '0;
        veto     = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            hist_any = hist_any | hist[c];
        end
        // Only history is consulted, so simultaneous edges on different
        // channels never veto each other, even in global mode.
        for (int unsigned c = 0; c < NCHAN; c++) begin
            raw[c]  = enable & sync_q[c][SYNC_STAGES-1] & ~sync_d[c];
            veto[c] = |(veto_mask & (veto_global ? hist_any : hist[c]));
        end
    end

    assign accept = raw & ~veto;
    assign reject = raw & veto;

    // -------------------------------------------------------------------------
    // Edge history (every raw edge enters, vetoed or not) and det register.
    // Written as a per-bit shift so VETO_DEPTH = 1 needs no special case.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                hist[c] <= '0;
            end
            det <= '0;
        end else begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                for (int unsigned k = 1; k < VETO_DEPTH; k++) begin
                    hist[c][k] <= hist[c][k-1];
                end
                hist[c][0] <= raw[c];
            end
            det <= accept;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating counters; a clear in the same cycle as an event drops it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear_cnt) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                hit_q[c]  <= '0;
                veto_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                if (accept[c] && (hit_q[c] != '1)) begin
                    hit_q[c] <= hit_q[c] + CNT_W'(1);
                end
                if (reject[c] && (veto_q[c] != '1)) begin
                    veto_q[c] <= veto_q[c] + CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output packing
    // -------------------------------------------------------------------------
    always_comb begin
        hit_cnt  = '0;
        veto_cnt = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            hit_cnt[c*CNT_W +: CNT_W]  = hit_q[c];
            veto_cnt[c*CNT_W +: CNT_W] = veto_q[c];
        end
    end

endmodule

// File: tb/tb_multichan_edge_detect_veto.sv
// -----------------------------------------------------------------------------
// tb_multichan_edge_detect_veto
//
// Bench for multichan_edge_detect_veto (NCHAN=4, VETO_DEPTH=3, SYNC_STAGES=2,
// CNT_W=4). Stimulus scenarios live in a table of per-channel pulse patterns
// with the expected det pattern and final counter values. Expected det values
// are queued when a stimulus cycle is driven and compared two cycles later,
// when the DUT produces the matching output. Saturation, enable, clear and
// reset corner cases are written out by hand.
// -----------------------------------------------------------------------------
module tb_multichan_edge_detect_veto;

    localparam int NCHAN = 4;
    localparam int VD    = 3;
    localparam int SS    = 2;
    localparam int CW    = 4;
    localparam int PLEN  = 12;

    logic              clk;
    logic              reset;
    logic [NCHAN-1:0]  pulse_in;
    logic              enable;
    logic [VD-1:0]     veto_mask;
    logic              veto_global;
    logic              clear_cnt;
    logic [NCHAN-1:0]  det;
    logic [NCHAN*CW-1:0] hit_cnt;
    logic [NCHAN*CW-1:0] veto_cnt;

    int checks = 0;
    int errors = 0;

    logic [NCHAN-1:0] sb [$];

    multichan_edge_detect_veto #(
        .NCHAN      (NCHAN),
        .VETO_DEPTH (VD),
        .SYNC_STAGES(SS),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .enable     (enable),
        .veto_mask  (veto_mask),
        .veto_global(veto_global),
        .clear_cnt  (clear_cnt),
        .det        (det),
        .hit_cnt    (hit_cnt),
        .veto_cnt   (veto_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pat[c][j]: pulse_in[c] level driven for step j.
    // dexp[c][j]: det[c] expected as a result of step j's capture.
    typedef struct packed {
        logic [VD-1:0]               mask;
        logic                        glob;
        logic                        en;
        logic [NCHAN-1:0][PLEN-1:0]  pat;
        logic [NCHAN-1:0][PLEN-1:0]  dexp;
        logic [NCHAN*CW-1:0]         hit;
        logic [NCHAN*CW-1:0]         veto;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [PLEN-1:0] bits(input int s, input int n);
        logic [PLEN-1:0] r;
        r = '0;
        for (int k = s; k < s + n; k++) r[k] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive one stimulus cycle, queue its expected
    // det, then compare the det produced for the step two cycles earlier.
    task automatic step(input logic [NCHAN-1:0] pin, input logic [NCHAN-1:0] e);
        logic [NCHAN-1:0] ex;
        pulse_in = pin;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() > 2) begin
            ex = sb.pop_front();
            check("det", {12'h000, det}, {12'h000, ex});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // ---------------- table setup ----------------
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '0;
            tbl[i].en = 1'b1;
        end
        // 0: single pulse ch0, no veto
        tbl[0].pat[0] = bits(1, 1);  tbl[0].dexp[0] = bits(1, 1);
        tbl[0].hit = 16'h0001;
        // 1: ch1 edges 3 cycles apart, mask 100 -> second vetoed
        tbl[1].mask = 3'b100;
        tbl[1].pat[1] = bits(1, 1) | bits(4, 1);  tbl[1].dexp[1] = bits(1, 1);
        tbl[1].hit = 16'h0010;  tbl[1].veto = 16'h0010;
        // 2: same with mask 011 -> both accepted
        tbl[2].mask = 3'b011;
        tbl[2].pat[1] = bits(1, 1) | bits(4, 1);
        tbl[2].dexp[1] = bits(1, 1) | bits(4, 1);
        tbl[2].hit = 16'h0020;
        // 3: global, mask 001, ch0 then ch2 one cycle later -> ch2 vetoed
        tbl[3].mask = 3'b001;  tbl[3].glob = 1'b1;
        tbl[3].pat[0] = bits(1, 1);  tbl[3].pat[2] = bits(2, 1);
        tbl[3].dexp[0] = bits(1, 1);
        tbl[3].hit = 16'h0001;  tbl[3].veto = 16'h0100;
        // 4: same stimulus per-channel -> both accepted
        tbl[4].mask = 3'b001;
        tbl[4].pat[0] = bits(1, 1);  tbl[4].pat[2] = bits(2, 1);
        tbl[4].dexp[0] = bits(1, 1); tbl[4].dexp[2] = bits(2, 1);
        tbl[4].hit = 16'h0101;
        // 5: enable low during 5 pulses -> nothing
        tbl[5].en = 1'b0;
        tbl[5].pat[0] = bits(1, 1) | bits(3, 1) | bits(5, 1) | bits(7, 1) | bits(9, 1);
        // 6: global, mask 111: simultaneous ch0/ch1 both accepted,
        //    ch3 two cycles later vetoed
        tbl[6].mask = 3'b111;  tbl[6].glob = 1'b1;
        tbl[6].pat[0] = bits(1, 1);  tbl[6].pat[1] = bits(1, 1);
        tbl[6].pat[3] = bits(3, 1);
        tbl[6].dexp[0] = bits(1, 1); tbl[6].dexp[1] = bits(1, 1);
        tbl[6].hit = 16'h0011;  tbl[6].veto = 16'h1000;
        // 7: long pulse on ch2 -> one det
        tbl[7].pat[2] = bits(1, 6);  tbl[7].dexp[2] = bits(1, 1);
        tbl[7].hit = 16'h0100;

        // ---------------- reset ----------------
        reset = 1'b1;  pulse_in = '0;  enable = 1'b1;
        veto_mask = '0;  veto_global = 1'b0;  clear_cnt = 1'b0;
        @(negedge clk);
        repeat (3) step('0, '0);
        check("reset_det", {12'h000, det}, 16'h0000);
        check("reset_hit", hit_cnt, 16'h0000);
        check("reset_veto", veto_cnt, 16'h0000);
        reset = 1'b0;
        repeat (2) step('0, '0);

        // ---------------- table-driven scenarios ----------------
        for (int i = 0; i < 8; i++) begin
            logic [NCHAN-1:0] p;
            logic [NCHAN-1:0] e;
            veto_mask   = tbl[i].mask;
            veto_global = tbl[i].glob;
            enable      = tbl[i].en;
            for (int j = 0; j < PLEN; j++) begin
                for (int c = 0; c < NCHAN; c++) begin
                    p[c] = tbl[i].pat[c][j];
                    e[c] = tbl[i].dexp[c][j];
                end
                step(p, e);
            end
            repeat (6) step('0, '0);
            check($sformatf("hit_s%0d", i), hit_cnt, tbl[i].hit);
            check($sformatf("veto_s%0d", i), veto_cnt, tbl[i].veto);
            clear_cnt = 1'b1;
            step('0, '0);
            clear_cnt = 1'b0;
        end

        // ---------------- saturation on ch3 ----------------
        veto_mask = '0;  veto_global = 1'b0;  enable = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step(4'b1000, 4'b1000);
            step('0, '0);
        end
        repeat (4) step('0, '0);
        check("sat_hit", hit_cnt, 16'hF000);
        check("sat_veto", veto_cnt, 16'h0000);

        // clear coincident with a hit: saturated counter, then from zero
        for (int n = 0; n < 2; n++) begin
            step(4'b1000, 4'b1000);
            step('0, '0);
            clear_cnt = 1'b1;
            step('0, '0);
            clear_cnt = 1'b0;
            repeat (3) step('0, '0);
            check($sformatf("clr_hit%0d", n), hit_cnt, 16'h0000);
        end

        // ---------------- enable raised while level high ----------------
        enable = 1'b0;
        repeat (4) step(4'b0010, '0);
        enable = 1'b1;
        repeat (3) step(4'b0010, '0);
        repeat (2) step('0, '0);
        step(4'b0010, 4'b0010);
        repeat (4) step('0, '0);
        check("en_rise_hit", hit_cnt, 16'h0010);

        // ---------------- reset one cycle after capture ----------------
        step(4'b0001, '0);
        reset = 1'b1;
        repeat (2) step('0, '0);
        reset = 1'b0;
        repeat (3) step('0, '0);
        check("rst_mid_hit", hit_cnt, 16'h0000);
        check("rst_mid_veto", veto_cnt, 16'h0000);

        // ---------------- level held across reset release ----------------
        reset = 1'b1;
        repeat (2) step(4'b0100, '0);
        reset = 1'b0;
        step(4'b0100, 4'b0100);
        repeat (6) step(4'b0100, '0);
        repeat (4) step('0, '0);
        check("rst_hold_hit", hit_cnt, 16'h0100);
        check("rst_hold_veto", veto_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multichan_edge_detect_veto.md
# multichan_edge_detect_veto

Parametrised, single-clock, multi-channel photon edge detector with configurable dead-time veto and per-channel hit/veto counters. Each asynchronous discriminator input is synchronised, rising-edge detected and emitted as a one-cycle `det` pulse. An edge is suppressed when an earlier edge (same channel, or any channel in global mode) falls inside a runtime-selected window of up to `VETO_DEPTH` cycles. It sits after the discriminator inputs and feeds the coincidence/counting logic in the `clk` domain.

## Interface
- `NCHAN`, 4: number of input channels (≥1)
- `VETO_DEPTH`, 3: veto window length in cycles (≥1)
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2)
- `CNT_W`, 16: width of each hit/veto counter

- `clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `pulse_in`  in  NCHAN  asynchronous photon pulses, arbitrary length
- `enable`  in  1  1 = detection active; 0 = ignore edges
- `veto_mask`  in  VETO_DEPTH  bit k set: veto edges occurring k+1 cycles after a prior edge
- `veto_global`  in  1  0 = per-channel history; 1 = OR of all channels' history
- `clear_cnt`  in  1  synchronous counter clear
- `det`  out  NCHAN  one-cycle detection pulse per channel (registered)
- `hit_cnt`  out  NCHAN*CNT_W  accepted-edge counts, channel c at [c*CNT_W +: CNT_W]
- `veto_cnt`  out  NCHAN*CNT_W  vetoed-edge counts, same packing

## Operation
- Per channel: shift chain `s[1..SYNC_STAGES]` samples `pulse_in[c]`; `s_d` is `s[SYNC_STAGES]` delayed one cycle.
- `raw[c] = enable & s[SYNC_STAGES] & ~s_d` (combinational).
- History `hist[c][VETO_DEPTH-1:0]`: each cycle `hist[c] <= {hist[c][VETO_DEPTH-2:0], raw[c]}`. `hist[c][k]` = raw edge k+1 cycles ago. Every raw edge enters the history, vetoed or not.
- `hsel[c] = veto_global ? OR over all channels of hist : hist[c]`; `veto[c] = |(veto_mask & hsel[c])`.
- Registered: `det[c] <= raw[c] & ~veto[c]`.
- Counters: `raw & ~veto` increments `hit_cnt[c]`; `raw & veto` increments `veto_cnt[c]`. Both saturate at 2^CNT_W−1, with no wrap.
- `clear_cnt`: all counters go to 0 next edge. Clear beats a same-cycle increment, so the count is 0 and that event is lost. Sync, history and `det` are unaffected.
- `enable` = 0: `raw` forced 0. No `det`, no counts, and zeros shift into history. Sync chains keep running, so a level already high when `enable` rises produces no edge.
- Simultaneous edges on different channels are independent. In global mode they do not veto each other in the same cycle, because only history is consulted.
- Mask or mode changes take effect on the next edge. History is not cleared.

## Timing
- Reset: `s`, `s_d`, `hist`, `det`, all counters = 0.
- A `pulse_in` held high through reset release is seen as a rising edge SYNC_STAGES+1 cycles later (`det` asserted if enabled).
- Latency: `pulse_in` high captured at edge T0 gives `det` high for exactly one cycle after edge T0+SYNC_STAGES. Counter update occurs at the same edge.
- Pulse length is irrelevant: one `det` per rising edge. Minimum detectable spacing is high ≥1 sample, low ≥1 sample, so raw edges on one channel are ≥2 cycles apart.
- `veto_mask[0]` only matters in global mode or with NCHAN>1 cross-veto. In per-channel mode, the 2-cycle spacing makes it a no-op.
- `reset` mid-pulse: all state cleared. The in-flight edge is lost unless the level is still high, per the reset rule above.

## Test plan
- Defaults, `veto_mask`=0, single 1-cycle pulse on ch0 at edge T0: `det[0]`=1 only in cycle after T0+2; `hit_cnt[0]`=1; others 0.
- Ch1 pulses 3 cycles apart, `veto_mask`=3'b100, per-channel: first `det`, second suppressed; `hit_cnt[1]`=1, `veto_cnt[1]`=1. With mask 3'b011: both detected.
- `veto_global`=1, mask 3'b001, ch0 edge then ch2 edge one cycle later: ch2 vetoed (`veto_cnt[2]`=1). Same stimulus with `veto_global`=0: both detected.
- `CNT_W`=4, 20 spaced pulses on ch3: `hit_cnt[3]` holds 15. Then `clear_cnt` coincident with a hit: counter reads 0.
- `enable`=0 during 5 pulses: no `det`, counts 0. Raise `enable` while `pulse_in` is high: no `det` until the next rising edge.
- Assert `reset` one cycle after a pulse captured: no `det`, counters 0. Hold `pulse_in` high across reset release: single `det` 3 cycles after release.
